frac_to_decimal_seq: RTL
========================

// Module: frac_to_decimal_seq
// PURPOSE
//   Iterative converter from an unsigned binary fraction (value = in_frac / 2^FRAC_W) to DIGITS
//   decimal fraction digits. Digits are produced MSD first by repeated multiply-by-10.
//   Outputs are packed BCD digits, their binary integer value and the count of leading zero digits.
//   Sits in the FLP->decimal path after mantissa alignment; valid/ready on both sides.
// PARAMETERS
//   FRAC_W  24  fraction width in bits
//   DIGITS  5   decimal digits delivered (>=1)
// PORTS
//   clk        in   1                    clock, rising edge
//   rst_n      in   1                    asynchronous active-low reset
//   in_valid   in   1                    in_frac valid
//   in_ready   out  1                    block idle, accepts a fraction
//   in_frac    in   FRAC_W               binary fraction bits, MSB = 2^-1
//   out_valid  out  1                    result valid, held until taken
//   out_ready  in   1                    downstream accepts result
//   out_bcd    out  4*DIGITS             BCD digits, [4*DIGITS-1 -: 4] = 10^-1 digit
//   out_bin    out  4*DIGITS             binary value of out_bcd as an integer (0..10^DIGITS-1)
//   out_lz     out  $clog2(DIGITS+1)     leading zero digits of out_bcd, DIGITS if all zero
//   out_carry  out  1                    rounding overflowed to 1.0 (FRAC_ROUND_EN only)
// BEHAVIOUR
//   - States: IDLE -> CONV -> [ROUND] -> DONE -> IDLE. in_ready = (state==IDLE).
//   - Reset (async, any state): state=IDLE, all out_* and internal regs = 0. Mid-conversion
//     reset discards work; in_ready=1 while and after reset.
//   - Accept on in_valid & in_ready edge: latch in_frac into F (FRAC_W bits), clear acc/digits, go CONV.
//   - CONV, one digit per cycle: P = (F<<3)+(F<<1) (FRAC_W+4 bits); digit = P[FRAC_W+3:FRAC_W];
//     F <= P[FRAC_W-1:0]; shift digit into BCD reg; acc <= acc*10 + digit (4*DIGITS bits, no overflow).
//   - Without macro: DIGITS CONV cycles, then DONE; out_valid rises DIGITS+1 edges after accept edge.
//   - DONE entry registers out_bcd, out_bin, out_lz (computed from final digits); out_valid=1.
//   - DONE: outputs stable while out_valid & !out_ready; in_valid ignored. On out_valid & out_ready
//     edge: out_valid=0, state=IDLE; next accept no earlier than the following edge (no overlap).
//   - Output data regs keep last value after handshake; only out_valid drops.
// CONFIGURATION
//   FRAC_ROUND_EN defined: CONV runs DIGITS+1 cycles; extra (guard) digit not stored. ROUND state,
//     one cycle: guard>=5 -> BCD +1 with decimal carry ripple, out_bin +1. All-9s + round ->
//     digits=0, out_bin=0, out_carry=1, out_lz=DIGITS. out_valid rises DIGITS+3 edges after accept.
//   Not defined: truncation, no ROUND state, out_carry tied 0.
// STRUCTURE
//   Package frac_dec_pkg: state enum (IDLE, CONV, ROUND, DONE), bcd_digit_t (4-bit), ROUND_THRESH=4'd5.
//   Sub-module bcd_incrementer #(DIGITS): combinational BCD +1, outputs sum and carry; used in ROUND.
//   Digit counter $clog2(DIGITS+2) bits; multiply-by-10 via shift-add, no multiplier.
// TESTING (FRAC_W=24, DIGITS=5)
//   24'h800000 -> bcd 20'h50000, bin 50000, lz 0; out_valid 6 edges after accept (8 with ROUND).
//   24'h028F5C (0.0099999904) -> trunc: bcd 00999, bin 999, lz 2; ROUND: bcd 01000, bin 1000, lz 1.
//   24'hFFFFFF -> trunc: bcd 99999, bin 99999, lz 0, carry 0; ROUND: bcd 0, bin 0, lz 5, carry 1.
//   24'h000001 -> bcd 0, bin 0, lz 5, carry 0 in both builds.
//   Back-pressure: out_ready=0 for 10 cycles -> outputs stable, in_ready=0, pulsed in_valid
//     ignored; out_ready=1 one cycle -> out_valid=0 next edge, in_ready=1.
//   Reset mid-CONV (rst_n low at 2nd CONV cycle) -> outputs 0 immediately, in_ready=1; next
//     conversion of 24'h800000 gives 50000.

Source files
------------

// File: rtl/frac_dec_pkg.sv
// Shared types and constants for the binary-fraction to decimal converter.
package frac_dec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t ROUND_THRESH = 4'd5;

endpackage

// File: rtl/bcd_incrementer.sv
// Combinational packed-BCD +1 with decimal carry ripple from the least significant digit.
module bcd_incrementer
    import frac_dec_pkg::*;
#(
    parameter int unsigned DIGITS = 5
) (
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic [4*DIGITS-1:0] sum,
    output logic                carry
);

    always_comb begin
        bcd_digit_t d;
        logic       c;
        sum = bcd_in;
        c   = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            d = bcd_in[4*i +: 4];
            if (c) begin
                if (d == 4'd9) begin
                    sum[4*i +: 4] = 4'd0;
                end else begin
                    sum[4*i +: 4] = d + 4'd1;
                    c = 1'b0;
                end
            end
        end
        carry = c;
    end

endmodule

// File: rtl/frac_to_decimal_seq.sv
// Iterative binary fraction -> DIGITS decimal digits converter (multiply-by-10, MSD first).
// Optional rounding on a guard digit is enabled by defining FRAC_ROUND_EN.
module frac_to_decimal_seq
    import frac_dec_pkg::*;
#(
    parameter int unsigned FRAC_W = 24,
    parameter int unsigned DIGITS = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [FRAC_W-1:0]            in_frac,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4*DIGITS-1:0]          out_bcd,
    output logic [4*DIGITS-1:0]          out_bin,
    output logic [$clog2(DIGITS+1)-1:0]  out_lz,
    output logic                         out_carry
);

    localparam int unsigned AW  = 4 * DIGITS;
    localparam int unsigned PW  = FRAC_W + 4;
    localparam int unsigned LZW = $clog2(DIGITS + 1);
    localparam int unsigned CW  = $clog2(DIGITS + 2);
`ifdef FRAC_ROUND_EN
    localparam int unsigned NCONV = DIGITS + 1;
`else
    localparam int unsigned NCONV = DIGITS;
`endif

    state_t            state_q, state_d;
    logic [FRAC_W-1:0] f_q, f_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     bcd_q, bcd_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic              out_valid_q, out_valid_d;
    logic [AW-1:0]     out_bcd_q, out_bcd_d;
    logic [AW-1:0]     out_bin_q, out_bin_d;
    logic [LZW-1:0]    out_lz_q, out_lz_d;
    logic [PW-1:0]     p;
    bcd_digit_t        digit;

    function automatic logic [LZW-1:0] lead_zeros(input logic [AW-1:0] b);
        logic [LZW-1:0] n;
        logic           seen;
        n    = '0;
        seen = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!seen && (b[AW-1-4*i -: 4] == 4'd0)) n = n + 1'b1;
            else                                     seen = 1'b1;
        end
        return n;
    endfunction

    // x10 as (F<<3)+(F<<1); the integer part is the next decimal digit.
    always_comb begin
        p     = (PW'(f_q) << 3) + (PW'(f_q) << 1);
        digit = p[PW-1 -: 4];
    end

`ifdef FRAC_ROUND_EN
    bcd_digit_t    guard_q, guard_d;
    logic          out_carry_q, out_carry_d;
    logic [AW-1:0] inc_sum;
    logic          inc_carry;

    bcd_incrementer #(.DIGITS(DIGITS)) u_inc (
        .bcd_in (bcd_q),
        .sum    (inc_sum),
        .carry  (inc_carry)
    );

    assign out_carry = out_carry_q;
`else
    assign out_carry = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        f_d         = f_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_bcd_d   = out_bcd_q;
        out_bin_d   = out_bin_q;
        out_lz_d    = out_lz_q;
`ifdef FRAC_ROUND_EN
        guard_d     = guard_q;
        out_carry_d = out_carry_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    f_d     = in_frac;
                    cnt_d   = '0;
                    bcd_d   = '0;
                    acc_d   = '0;
                    state_d = CONV;
`ifdef FRAC_ROUND_EN
                    guard_d = '0;
`endif
                end
            end
            CONV: begin
                if (cnt_q < CW'(NCONV)) begin
                    f_d   = p[FRAC_W-1:0];
                    cnt_d = cnt_q + 1'b1;
`ifdef FRAC_ROUND_EN
                    if (cnt_q == CW'(DIGITS)) begin
                        guard_d = digit;
                    end else begin
                        bcd_d = (bcd_q << 4) | AW'(digit);
                        acc_d = (acc_q << 3) + (acc_q << 1) + AW'(digit);
                    end
`else
                    bcd_d = (bcd_q << 4) | AW'(digit);
                    acc_d = (acc_q << 3) + (acc_q << 1) + AW'(digit);
`endif
                end else begin
`ifdef FRAC_ROUND_EN
                    state_d = ROUND;
`else
                    out_bcd_d   = bcd_q;
                    out_bin_d   = acc_q;
                    out_lz_d    = lead_zeros(bcd_q);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`endif
                end
            end
            ROUND: begin
`ifdef FRAC_ROUND_EN
                out_bcd_d   = bcd_q;
                out_bin_d   = acc_q;
                out_lz_d    = lead_zeros(bcd_q);
                out_carry_d = 1'b0;
                if (guard_q >= ROUND_THRESH) begin
                    if (inc_carry) begin
                        out_bcd_d   = '0;
                        out_bin_d   = '0;
                        out_lz_d    = LZW'(DIGITS);
                        out_carry_d = 1'b1;
                    end else begin
                        out_bcd_d = inc_sum;
                        out_bin_d = acc_q + AW'(1);
                        out_lz_d  = lead_zeros(inc_sum);
                    end
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            f_q         <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_bcd_q   <= '0;
            out_bin_q   <= '0;
            out_lz_q    <= '0;
`ifdef FRAC_ROUND_EN
            guard_q     <= '0;
            out_carry_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            f_q         <= f_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_bcd_q   <= out_bcd_d;
            out_bin_q   <= out_bin_d;
            out_lz_q    <= out_lz_d;
`ifdef FRAC_ROUND_EN
            guard_q     <= guard_d;
            out_carry_q <= out_carry_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_bcd   = out_bcd_q;
    assign out_bin   = out_bin_q;
    assign out_lz    = out_lz_q;

endmodule
